// File: rtl/johnson_decoder_8bit_pkg.sv
// Shared definitions for the Johnson decoder: FSM state encodings, the
// Johnson<->index mapping and the active-low 7-segment glyph table.
package johnson_decoder_8bit_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_TRACK = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  typedef struct packed {
    logic       legal;
    logic [3:0] idx;
  } jdec_t;

  localparam logic [6:0] SEG_ZERO = 7'b1000000;

  // Index k<8 fills k ones from the LSB; index 8+k is the complement of that fill.
  function automatic logic [7:0] johnson_encode(input logic [3:0] idx);
    logic [7:0] mask;
    mask = (8'd1 << idx[2:0]) - 8'd1;
    return idx[3] ? ~mask : mask;
  endfunction

  function automatic jdec_t johnson_decode(input logic [7:0] code);
    jdec_t res;
    res.legal = 1'b0;
    res.idx   = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (code == johnson_encode(i[3:0])) begin
        res.legal = 1'b1;
        res.idx   = i[3:0];
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  function automatic logic [6:0] hex_to_seg(input logic [3:0] value);
    logic [6:0] seg;
    case (value)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      4'hF:    seg = 7'b0001110;
      default: seg = 7'b1111111;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/johnson_decoder_8bit_hex_to_7seg.sv
// Hex nibble to active-low 7-segment pattern (bit0=a .. bit6=g).
module johnson_decoder_8bit_hex_to_7seg
  import johnson_decoder_8bit_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] seg
);

  // Pure table lookup; the caller registers the result.
  always_comb begin
    seg = hex_to_seg(value);
  end

endmodule

// File: rtl/johnson_decoder_8bit.sv
// Johnson code checker: decodes J to an index, tracks step continuity and counts errors.
// Optional feature: define JOHNSON_DIR_EN to accept down-steps (delta -1) and report dir=0.
module johnson_decoder_8bit
  import johnson_decoder_8bit_pkg::*;
#(
  parameter logic [3:0] ERR_SAT = 4'hF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [7:0] J,
  output logic [3:0] idx,
  output logic       idx_vld,
  output logic       dir,
  output logic       err_ill,
  output logic       err_skip,
  output logic       fault,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1
);

  state_t     state_r, state_s;
  jdec_t      dec_s;
  logic [3:0] delta_s;
  logic       allowed_s;
  logic [3:0] idx_s;
  logic       dir_s;
  logic       vld_s, ill_s, skip_s;
  logic [3:0] err_cnt_r, err_cnt_s;
  logic [6:0] hex0_s, hex1_s;

  // Decode the sample and classify the step relative to the held index.
  always_comb begin
    dec_s   = johnson_decode(J);
    delta_s = dec_s.idx - idx;
`ifdef JOHNSON_DIR_EN
    allowed_s = (delta_s == 4'd0) || (delta_s == 4'd1) || (delta_s == 4'hF);
`else
    allowed_s = (delta_s == 4'd0) || (delta_s == 4'd1);
`endif
  end

  // Next-state and pulse generation for the tracking FSM.
  always_comb begin
    state_s = state_r;
    idx_s   = idx;
    dir_s   = dir;
    vld_s   = 1'b0;
    ill_s   = 1'b0;
    skip_s  = 1'b0;
    if (en) begin
      case (state_r)
        S_IDLE: begin
          if (dec_s.legal) begin
            idx_s   = dec_s.idx;
            vld_s   = 1'b1;
            state_s = S_TRACK;
          end else begin
            ill_s = 1'b1;
          end
        end
        S_TRACK, S_FAULT: begin
          if (!dec_s.legal) begin
            ill_s   = 1'b1;
            state_s = S_FAULT;
          end else if (allowed_s) begin
            idx_s   = dec_s.idx;
            vld_s   = 1'b1;
            state_s = S_TRACK;
            if (delta_s != 4'd0) begin
              dir_s = (delta_s == 4'd1);
            end else begin
              dir_s = dir;
            end
          end else begin
            // A skip resynchronises on the new index so one glitch costs one error.
            idx_s   = dec_s.idx;
            vld_s   = 1'b1;
            skip_s  = 1'b1;
            state_s = S_FAULT;
          end
        end
        default: begin
          state_s = S_IDLE;
        end
      endcase
    end else begin
      state_s = state_r;
    end

    if ((ill_s || skip_s) && (err_cnt_r < ERR_SAT)) begin
      err_cnt_s = err_cnt_r + 4'd1;
    end else begin
      err_cnt_s = err_cnt_r;
    end
  end

  johnson_decoder_8bit_hex_to_7seg u_hex0 (
    .value (idx_s),
    .seg   (hex0_s)
  );

  johnson_decoder_8bit_hex_to_7seg u_hex1 (
    .value (err_cnt_s),
    .seg   (hex1_s)
  );

  // State and output registers; displays are registered from next-state values to stay aligned.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= S_IDLE;
      idx       <= 4'd0;
      idx_vld   <= 1'b0;
      dir       <= 1'b1;
      err_ill   <= 1'b0;
      err_skip  <= 1'b0;
      fault     <= 1'b0;
      err_cnt_r <= 4'd0;
      HEX0      <= SEG_ZERO;
      HEX1      <= SEG_ZERO;
    end else begin
      state_r   <= state_s;
      idx       <= idx_s;
      idx_vld   <= vld_s;
      dir       <= dir_s;
      err_ill   <= ill_s;
      err_skip  <= skip_s;
      fault     <= (state_s == S_FAULT);
      err_cnt_r <= err_cnt_s;
      HEX0      <= hex0_s;
      HEX1      <= hex1_s;
    end
  end

endmodule

// File: tb/tb_johnson_decoder_8bit.sv
// Directed bench for johnson_decoder_8bit: walk, illegal/skip recovery, down-step, saturation, reset.
module tb_johnson_decoder_8bit;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [7:0] J;
  logic [3:0] idx;
  logic       idx_vld, dir, err_ill, err_skip, fault;
  logic [6:0] HEX0, HEX1;

  int errors = 0;
  int checks = 0;

  johnson_decoder_8bit #(.ERR_SAT(4'hF)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .J        (J),
    .idx      (idx),
    .idx_vld  (idx_vld),
    .dir      (dir),
    .err_ill  (err_ill),
    .err_skip (err_skip),
    .fault    (fault),
    .HEX0     (HEX0),
    .HEX1     (HEX1)
  );

  always #5 clk = ~clk;

  // Drive one sample, then observe 1 time unit after the consuming edge.
  task automatic apply(input logic e, input logic [7:0] j);
    en = e;
    J  = j;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    apply(1'b0, 8'h00);
    reset = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {idx, idx_vld, dir, err_ill, err_skip, fault}
  function automatic logic [15:0] st(input logic [3:0] i, input logic v, input logic d,
                                     input logic il, input logic sk, input logic f);
    return {7'd0, i, v, d, il, sk, f};
  endfunction

  logic [7:0] walk [17] = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F,
                            8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00};

  initial begin
    reset = 1'b1;
    en    = 1'b0;
    J     = 8'h00;
    #2;

    // Reset state
    do_reset();
    chk("rst_state", st(idx, idx_vld, dir, err_ill, err_skip, fault), st(4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    chk("rst_hex0", {9'd0, HEX0}, {9'd0, 7'b1000000});
    chk("rst_hex1", {9'd0, HEX1}, {9'd0, 7'b1000000});

    // 1: full walk with wrap
    for (int i = 0; i < 17; i++) begin
      apply(1'b1, walk[i]);
      chk("walk", st(idx, idx_vld, dir, err_ill, err_skip, fault),
          st(4'(i % 16), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
      if (i == 10) chk("walk_hex0_A", {9'd0, HEX0}, {9'd0, 7'b0001000});
      if (i == 15) chk("walk_hex0_F", {9'd0, HEX0}, {9'd0, 7'b0001110});
    end
    chk("walk_hex1", {9'd0, HEX1}, {9'd0, 7'b1000000});
    apply(1'b0, 8'h01);
    chk("en_low_hold", st(idx, idx_vld, dir, err_ill, err_skip, fault), st(4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));

    // 2: illegal from TRACK, then recover
    do_reset();
    apply(1'b1, 8'h00); apply(1'b1, 8'h01); apply(1'b1, 8'h03); apply(1'b1, 8'h07);
    chk("trk_idx3", st(idx, idx_vld, dir, err_ill, err_skip, fault), st(4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    apply(1'b1, 8'h05);
    chk("ill_pulse", st(idx, idx_vld, dir, err_ill, err_skip, fault), st(4'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1));
    apply(1'b1, 8'h0F);
    chk("ill_recover", st(idx, idx_vld, dir, err_ill, err_skip, fault), st(4'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    chk("ill_hex1", {9'd0, HEX1}, {9'd0, 7'b1111001});
    chk("ill_hex0", {9'd0, HEX0}, {9'd0, 7'b0011001});

    // 3: skip from idx 2 to 5, then recover
    do_reset();
    apply(1'b1, 8'h00); apply(1'b1, 8'h01); apply(1'b1, 8'h03);
    apply(1'b1, 8'h1F);
    chk("skip_pulse", st(idx, idx_vld, dir, err_ill, err_skip, fault), st(4'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1));
    apply(1'b1, 8'h3F);
    chk("skip_recover", st(idx, idx_vld, dir, err_ill, err_skip, fault), st(4'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));

    // 4: down-step 0 -> 15
    do_reset();
    apply(1'b1, 8'h00);
    apply(1'b1, 8'h80);
`ifdef JOHNSON_DIR_EN
    chk("down_step", st(idx, idx_vld, dir, err_ill, err_skip, fault), st(4'd15, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
`else
    chk("down_step", st(idx, idx_vld, dir, err_ill, err_skip, fault), st(4'd15, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1));
`endif

    // 5: error counter saturation
    do_reset();
    apply(1'b1, 8'h55);
    chk("sat_first", st(idx, idx_vld, dir, err_ill, err_skip, fault), st(4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    chk("sat_hex1_1", {9'd0, HEX1}, {9'd0, 7'b1111001});
    for (int i = 1; i < 20; i++) apply(1'b1, 8'h55);
    chk("sat_hex1_F", {9'd0, HEX1}, {9'd0, 7'b0001110});
    apply(1'b1, 8'h55);
    chk("sat_hold", {9'd0, HEX1}, {9'd0, 7'b0001110});
    apply(1'b0, 8'h55);
    chk("sat_en_low", {15'd0, err_ill}, 16'd0);

    // 6: reset mid-stream with en=1 and illegal J
    reset = 1'b1;
    apply(1'b1, 8'h55);
    reset = 1'b0;
    chk("mid_rst_state", st(idx, idx_vld, dir, err_ill, err_skip, fault), st(4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    chk("mid_rst_hex1", {9'd0, HEX1}, {9'd0, 7'b1000000});
    apply(1'b1, 8'h0F);
    chk("post_rst_first", st(idx, idx_vld, dir, err_ill, err_skip, fault), st(4'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
